// File: rtl/rs_add.sv
// rs_add: reservation station for the add execution unit.
// Holds dispatched add micro-ops until both 16-bit operands are available.
// Operands are captured from two CDB channels (channel 0 wins on a double hit).
// Each cycle the oldest ready entry is selected into a registered issue stage.
// Optional feature: define RS_ADD_BYPASS_EN to let an entry whose last operand
// arrives on the CDB this cycle issue at the same edge. The operand is taken
// straight from the bus. The default build leaves the macro undefined.
module rs_add #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           freeze_back,
  input  logic                           valid_dispatch,
  output logic                           ready_dispatch,
  input  logic [4:0]                     Pw_dispatch,
  input  logic [4:0]                     tag_ROB_dispatch,
  input  logic [4:0]                     Pa_dispatch,
  input  logic [4:0]                     Pb_dispatch,
  input  logic                           valid_A_dispatch,
  input  logic                           valid_B_dispatch,
  input  logic [15:0]                    busA_dispatch,
  input  logic [15:0]                    busB_dispatch,
  input  logic                           valid_cdb0,
  input  logic                           valid_cdb1,
  input  logic [4:0]                     Pw_cdb0,
  input  logic [4:0]                     Pw_cdb1,
  input  logic [15:0]                    Result_cdb0,
  input  logic [15:0]                    Result_cdb1,
  output logic                           valid_add,
  output logic [4:0]                     Pw_add,
  output logic [4:0]                     tag_ROB_add,
  output logic [15:0]                    busA_add,
  output logic [15:0]                    busB_add,
  output logic [$clog2(DEPTH+1)-1:0]     count_rs
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = 5;
  localparam int unsigned DW = 16;

`ifdef RS_ADD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Entry storage. age is the rank among valid entries, 0 = oldest.
  // Ranks stay dense, so no counter ever wraps.
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] rdy_a_q, rdy_a_d, rdy_b_q, rdy_b_d;
  logic [AW-1:0]    age_q   [DEPTH];
  logic [AW-1:0]    age_d   [DEPTH];
  logic [TW-1:0]    pw_q    [DEPTH];
  logic [TW-1:0]    pw_d    [DEPTH];
  logic [TW-1:0]    rob_q   [DEPTH];
  logic [TW-1:0]    rob_d   [DEPTH];
  logic [TW-1:0]    tag_a_q [DEPTH];
  logic [TW-1:0]    tag_a_d [DEPTH];
  logic [TW-1:0]    tag_b_q [DEPTH];
  logic [TW-1:0]    tag_b_d [DEPTH];
  logic [DW-1:0]    val_a_q [DEPTH];
  logic [DW-1:0]    val_a_d [DEPTH];
  logic [DW-1:0]    val_b_q [DEPTH];
  logic [DW-1:0]    val_b_d [DEPTH];

  // Issue stage and occupancy.
  logic          iss_vld_q, iss_vld_d;
  logic [TW-1:0] iss_pw_q, iss_pw_d;
  logic [TW-1:0] iss_rob_q, iss_rob_d;
  logic [DW-1:0] iss_a_q, iss_a_d;
  logic [DW-1:0] iss_b_q, iss_b_d;
  logic [CW-1:0] count_q, count_d;
  logic          rdy_disp_q, rdy_disp_d;

  // Per-entry wakeup results.
  logic [DEPTH-1:0] wk_a, wk_b, elig;
  logic [DW-1:0]    wv_a [DEPTH];
  logic [DW-1:0]    wv_b [DEPTH];
  logic [DW-1:0]    op_a [DEPTH];
  logic [DW-1:0]    op_b [DEPTH];

  logic          sel_found;
  logic [AW-1:0] sel_idx;
  logic [AW-1:0] sel_age;
  logic [DW-1:0] sel_a, sel_b;
  logic          free_found;
  logic [AW-1:0] free_idx;
  logic          do_issue, do_disp;
  logic          dhit_a0, dhit_a1, dhit_b0, dhit_b1;

  // CDB tag match per stored operand, plus select eligibility.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      wk_a[i] = !rdy_a_q[i] && ((valid_cdb0 && (Pw_cdb0 == tag_a_q[i])) ||
                                (valid_cdb1 && (Pw_cdb1 == tag_a_q[i])));
      wk_b[i] = !rdy_b_q[i] && ((valid_cdb0 && (Pw_cdb0 == tag_b_q[i])) ||
                                (valid_cdb1 && (Pw_cdb1 == tag_b_q[i])));
      wv_a[i] = (valid_cdb0 && (Pw_cdb0 == tag_a_q[i])) ? Result_cdb0 : Result_cdb1;
      wv_b[i] = (valid_cdb0 && (Pw_cdb0 == tag_b_q[i])) ? Result_cdb0 : Result_cdb1;
      op_a[i] = rdy_a_q[i] ? val_a_q[i] : wv_a[i];
      op_b[i] = rdy_b_q[i] ? val_b_q[i] : wv_b[i];
      elig[i] = vld_q[i] && (rdy_a_q[i] || (BYPASS && wk_a[i]))
                         && (rdy_b_q[i] || (BYPASS && wk_b[i]));
    end
  end

  // Oldest eligible entry and lowest-index free slot.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_age    = '0;
    sel_a      = '0;
    sel_b      = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (elig[i] && (!sel_found || (age_q[i] < sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = AW'(i);
        sel_age   = age_q[i];
        sel_a     = op_a[i];
        sel_b     = op_b[i];
      end
      if (!vld_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = AW'(i);
      end
    end
  end

  // Issue and dispatch qualifiers; dispatch-cycle operand capture hits.
  always_comb begin
    do_issue = sel_found && !freeze_back && !flush;
    do_disp  = valid_dispatch && rdy_disp_q && free_found && !flush;
    dhit_a0  = valid_cdb0 && (Pw_cdb0 == Pa_dispatch);
    dhit_a1  = valid_cdb1 && (Pw_cdb1 == Pa_dispatch);
    dhit_b0  = valid_cdb0 && (Pw_cdb0 == Pb_dispatch);
    dhit_b1  = valid_cdb1 && (Pw_cdb1 == Pb_dispatch);
  end

  // Entry next state: wakeup, free on issue, age compaction, dispatch write, flush.
  always_comb begin
    vld_d   = vld_q;
    rdy_a_d = rdy_a_q;
    rdy_b_d = rdy_b_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      age_d[i]   = age_q[i];
      pw_d[i]    = pw_q[i];
      rob_d[i]   = rob_q[i];
      tag_a_d[i] = tag_a_q[i];
      tag_b_d[i] = tag_b_q[i];
      val_a_d[i] = val_a_q[i];
      val_b_d[i] = val_b_q[i];
      if (vld_q[i] && wk_a[i]) begin
        rdy_a_d[i] = 1'b1;
        val_a_d[i] = wv_a[i];
      end
      if (vld_q[i] && wk_b[i]) begin
        rdy_b_d[i] = 1'b1;
        val_b_d[i] = wv_b[i];
      end
      if (do_issue && vld_q[i] && (age_q[i] > sel_age)) begin
        age_d[i] = age_q[i] - AW'(1);
      end
      if (do_issue && (AW'(i) == sel_idx)) begin
        vld_d[i] = 1'b0;
      end
      if (do_disp && (AW'(i) == free_idx)) begin
        vld_d[i]   = 1'b1;
        age_d[i]   = AW'(count_q - CW'(do_issue));
        pw_d[i]    = Pw_dispatch;
        rob_d[i]   = tag_ROB_dispatch;
        tag_a_d[i] = Pa_dispatch;
        tag_b_d[i] = Pb_dispatch;
        rdy_a_d[i] = valid_A_dispatch || dhit_a0 || dhit_a1;
        rdy_b_d[i] = valid_B_dispatch || dhit_b0 || dhit_b1;
        val_a_d[i] = valid_A_dispatch ? busA_dispatch :
                     (dhit_a0 ? Result_cdb0 : Result_cdb1);
        val_b_d[i] = valid_B_dispatch ? busB_dispatch :
                     (dhit_b0 ? Result_cdb0 : Result_cdb1);
      end
      if (flush) begin
        vld_d[i] = 1'b0;
      end
    end
  end

  // Issue register, occupancy count and dispatch-ready flag.
  always_comb begin
    iss_vld_d = iss_vld_q;
    iss_pw_d  = iss_pw_q;
    iss_rob_d = iss_rob_q;
    iss_a_d   = iss_a_q;
    iss_b_d   = iss_b_q;
    if (flush) begin
      iss_vld_d = 1'b0;
    end else if (!freeze_back) begin
      iss_vld_d = sel_found;
      if (sel_found) begin
        iss_pw_d  = pw_q[sel_idx];
        iss_rob_d = rob_q[sel_idx];
        iss_a_d   = sel_a;
        iss_b_d   = sel_b;
      end
    end
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(do_disp) - CW'(do_issue);
    end
    rdy_disp_d = (count_d < CW'(DEPTH));
  end

  // Entry storage flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q   <= '0;
      rdy_a_q <= '0;
      rdy_b_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        age_q[i]   <= '0;
        pw_q[i]    <= '0;
        rob_q[i]   <= '0;
        tag_a_q[i] <= '0;
        tag_b_q[i] <= '0;
        val_a_q[i] <= '0;
        val_b_q[i] <= '0;
      end
    end else begin
      vld_q   <= vld_d;
      rdy_a_q <= rdy_a_d;
      rdy_b_q <= rdy_b_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        age_q[i]   <= age_d[i];
        pw_q[i]    <= pw_d[i];
        rob_q[i]   <= rob_d[i];
        tag_a_q[i] <= tag_a_d[i];
        tag_b_q[i] <= tag_b_d[i];
        val_a_q[i] <= val_a_d[i];
        val_b_q[i] <= val_b_d[i];
      end
    end
  end

  // Issue stage and status flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_vld_q  <= 1'b0;
      iss_pw_q   <= '0;
      iss_rob_q  <= '0;
      iss_a_q    <= '0;
      iss_b_q    <= '0;
      count_q    <= '0;
      rdy_disp_q <= 1'b1;
    end else begin
      iss_vld_q  <= iss_vld_d;
      iss_pw_q   <= iss_pw_d;
      iss_rob_q  <= iss_rob_d;
      iss_a_q    <= iss_a_d;
      iss_b_q    <= iss_b_d;
      count_q    <= count_d;
      rdy_disp_q <= rdy_disp_d;
    end
  end

  assign valid_add      = iss_vld_q;
  assign Pw_add         = iss_pw_q;
  assign tag_ROB_add    = iss_rob_q;
  assign busA_add       = iss_a_q;
  assign busB_add       = iss_b_q;
  assign count_rs       = count_q;
  assign ready_dispatch = rdy_disp_q;

endmodule

// File: doc/rs_add.md
# rs_add

Reservation station for the add execution unit in the out-of-order back end. Holds dispatched add micro-ops until both 16-bit source operands are available, captures operands from two result-broadcast (CDB) channels, selects the oldest ready entry each cycle, and drives the add unit's issue inputs from a registered issue stage. Sits between rename/dispatch and the add unit; obeys the same `flush` / `freeze_back` controls.

## Interface
- `DEPTH`, 4: number of entries (2..16).
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `flush` input 1: discard all entries and the issue register.
- `freeze_back` input 1: back-end stall; hold the issue register, no selection.
- `valid_dispatch` input 1: dispatch request.
- `ready_dispatch` output 1: a free entry exists.
- `Pw_dispatch`, `tag_ROB_dispatch` input 5 each: destination physical register and ROB tag.
- `Pa_dispatch`, `Pb_dispatch` input 5 each: source physical register tags.
- `valid_A_dispatch`, `valid_B_dispatch` input 1 each: operand already available on the bus.
- `busA_dispatch`, `busB_dispatch` input 16 each: operand values, meaningful when the matching valid is 1.
- `valid_cdb0`, `valid_cdb1` input 1 each: broadcast valid.
- `Pw_cdb0`, `Pw_cdb1` input 5 each: broadcast destination tag.
- `Result_cdb0`, `Result_cdb1` input 16 each: broadcast value.
- `valid_add` output 1: issue valid.
- `Pw_add`, `tag_ROB_add` output 5 each: issued destination and ROB tag.
- `busA_add`, `busB_add` output 16 each: issued operands.
- `count_rs` output $clog2(DEPTH+1): occupied entries.

## Operation
- Entry fields: valid, age, Pw, tag_ROB, tag A/B, rdy A/B, value A/B.
- Dispatch: accepted when `valid_dispatch && ready_dispatch && !flush`. Written to the lowest-index free entry and marked youngest. Accepted regardless of `freeze_back`.
- Dispatch-time capture: a not-ready operand whose tag matches a valid CDB channel in the same cycle is stored ready with that CDB value.
- Wakeup: every cycle, any valid entry operand with rdy=0 and tag equal to a valid `Pw_cdbN` latches `Result_cdbN` and sets rdy. This also happens under `freeze_back`. If both channels match, channel 0 wins.
- Select, when `!freeze_back`: among entries with valid && rdyA && rdyB, pick the oldest. Load its fields into the issue register with `valid_add`=1, and free the entry at the same edge. If none is ready, `valid_add`=0.
- `freeze_back`: issue register and all `*_add` outputs hold, and no entry is freed.
- `flush`: at the next edge all entries are invalidated, `valid_add`=0, and that cycle's dispatch is dropped. `flush` has priority over `freeze_back`.
- `ready_dispatch` = `count_rs < DEPTH`, computed from registered state only. It does not credit a same-cycle issue.
- Simultaneous dispatch and issue in one cycle is legal. Count updates by +1, -1 or 0 accordingly.
- Age ordering: relative order is preserved across frees. Wrap-around of any age counter never inverts order.

## Timing
- Reset (`rst`=0, async): all entries invalid; `valid_add`, `Pw_add`, `tag_ROB_add`, `busA_add`, `busB_add`, `count_rs` = 0; `ready_dispatch`=1.
- Dispatch with both operands ready, accepted at edge E0: `valid_add`=1 after E0+1.
- Last operand broadcast in cycle t: operand stored at the end-of-cycle-t edge. Issue follows one edge later (`valid_add` after edge t+1). With bypass enabled, issue happens at the end-of-cycle-t edge instead (see Configuration).
- Issue output is registered; there is no combinational path from `valid_dispatch` to `*_add`.

## Configuration
- `RS_ADD_BYPASS_EN` defined:
  - A stored entry whose last missing operand matches a CDB channel in the current cycle is select-eligible that cycle.
  - Its operand comes straight from `Result_cdbN` into the issue register, saving one cycle.
  - Dispatch-cycle entries are never bypassed.
- Not defined: only stored rdy bits are considered; wakeup-to-issue is 2 edges.

## Test plan
- Reset then dispatch Pw=3, ROB=7, A=0x0010, B=0x0020, both ready -> one cycle later `valid_add`=1, Pw_add=3, tag_ROB_add=7, busA_add=0x0010, busB_add=0x0020; `count_rs` back to 0.
- Dispatch entry with Pb=9 not ready; cdb1 broadcasts Pw=9, 0xBEEF in cycle t -> issue after edge t+1 (after edge t with `RS_ADD_BYPASS_EN`), busB_add=0xBEEF.
- Fill DEPTH=4 entries with no ready operands -> `ready_dispatch`=0; a fifth `valid_dispatch` is ignored and `count_rs` stays 4.
- Two entries both ready, dispatched in order X then Y -> X issues first, Y on the next cycle.
- Hold `freeze_back` for 3 cycles with `valid_add`=1 -> outputs unchanged; a CDB wakeup during the freeze is still captured; release -> next oldest ready issues.
- `flush` with 3 entries and `valid_add`=1, plus a concurrent dispatch -> next cycle `count_rs`=0, `valid_add`=0, and the dispatched op is absent.
